decode_execute_stage: RTL and testbench

//  Decodes RV32I integer ALU instructions (OP, OP-IMM, LUI, AUIPC) and registers the results in the ID/EX pipeline register.

---
 rtl/decode_execute_stage.sv | 230 +++++++++++++++++++++++
 tb/tb_decode_execute_stage.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_execute_stage.sv
// RV32I ALU-class decoder (OP, OP-IMM, LUI, AUIPC) with a registered ID/EX
// output stage and valid/ready handshakes toward fetch and the integer ALU.
module decode_execute_stage #(
    parameter int XLEN       = 32,
    parameter int SEL_SIZE   = 4,
    parameter int SHIFT_SIZE = 5,
    parameter int REG_ADDR   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instr,
    input  logic [XLEN-1:0]       pc,
    output logic [REG_ADDR-1:0]   rs1_addr,
    output logic [REG_ADDR-1:0]   rs2_addr,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    output logic                  alu_valid,
    input  logic                  alu_ready,
    output logic [SEL_SIZE-1:0]   alu_sel,
    output logic [SHIFT_SIZE-1:0] alu_shift_amt,
    output logic [XLEN-1:0]       alu_data_a,
    output logic [XLEN-1:0]       alu_data_b,
    output logic [REG_ADDR-1:0]   rd_addr,
    output logic                  rd_we,
    output logic                  illegal,
    output logic [31:0]           issue_count
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [SEL_SIZE-1:0] SEL_ADD   = SEL_SIZE'(0);
    localparam logic [SEL_SIZE-1:0] SEL_SUB   = SEL_SIZE'(1);
    localparam logic [SEL_SIZE-1:0] SEL_SLT   = SEL_SIZE'(2);
    localparam logic [SEL_SIZE-1:0] SEL_SLTU  = SEL_SIZE'(3);
    localparam logic [SEL_SIZE-1:0] SEL_AND   = SEL_SIZE'(4);
    localparam logic [SEL_SIZE-1:0] SEL_OR    = SEL_SIZE'(5);
    localparam logic [SEL_SIZE-1:0] SEL_XOR   = SEL_SIZE'(6);
    localparam logic [SEL_SIZE-1:0] SEL_SLL   = SEL_SIZE'(7);
    localparam logic [SEL_SIZE-1:0] SEL_SRL   = SEL_SIZE'(8);
    localparam logic [SEL_SIZE-1:0] SEL_SRA   = SEL_SIZE'(9);
    localparam logic [SEL_SIZE-1:0] SEL_LUI   = SEL_SIZE'(10);
    localparam logic [SEL_SIZE-1:0] SEL_AUIPC = SEL_SIZE'(11);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];

    logic is_op, is_imm, is_lui, is_auipc;

    assign is_op    = (opcode == OPC_OP);
    assign is_imm   = (opcode == OPC_IMM);
    assign is_lui   = (opcode == OPC_LUI);
    assign is_auipc = (opcode == OPC_AUIPC);

    logic [SEL_SIZE-1:0] base_sel;

    always_comb begin
        base_sel = SEL_ADD;
        unique case (funct3)
            3'b000: base_sel = SEL_ADD;
            3'b001: base_sel = SEL_SLL;
            3'b010: base_sel = SEL_SLT;
            3'b011: base_sel = SEL_SLTU;
            3'b100: base_sel = SEL_XOR;
            3'b101: base_sel = SEL_SRL;
            3'b110: base_sel = SEL_OR;
            3'b111: base_sel = SEL_AND;
            default: base_sel = SEL_ADD;
        endcase
    end

    logic [SEL_SIZE-1:0]   dec_sel;
    logic [SHIFT_SIZE-1:0] dec_sh;
    logic [XLEN-1:0]       dec_a;
    logic [XLEN-1:0]       dec_b;
    logic                  dec_legal;

    always_comb begin
        dec_sel   = SEL_ADD;
        dec_sh    = '0;
        dec_a     = '0;
        dec_b     = '0;
        dec_legal = 1'b0;
        unique case (1'b1)
            is_op: begin
                dec_a  = rs1_data;
                dec_b  = rs2_data;
                dec_sh = rs2_data[SHIFT_SIZE-1:0];
                if (funct7 == F7_BASE) begin
                    dec_legal = 1'b1;
                    dec_sel   = base_sel;
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_sel   = SEL_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_legal = 1'b1;
                    dec_sel   = SEL_SRA;
                end
            end
            is_imm: begin
                dec_a     = rs1_data;
                dec_b     = {{(XLEN-12){instr[31]}}, instr[31:20]};
                dec_sh    = instr[20 +: SHIFT_SIZE];
                dec_sel   = base_sel;
                dec_legal = 1'b1;
                // Shift-immediates reuse the top imm bits as funct7
                if (funct3 == 3'b001 && funct7 != F7_BASE) begin
                    dec_legal = 1'b0;
                end
                if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT) begin
                        dec_sel = SEL_SRA;
                    end else if (funct7 != F7_BASE) begin
                        dec_legal = 1'b0;
                    end
                end
            end
            is_lui: begin
                dec_legal = 1'b1;
                dec_sel   = SEL_LUI;
                dec_a     = {{(XLEN-20){1'b0}}, instr[31:12]};
            end
            is_auipc: begin
                dec_legal = 1'b1;
                dec_sel   = SEL_AUIPC;
                dec_a     = {{(XLEN-20){1'b0}}, instr[31:12]};
                dec_b     = pc;
            end
            default: dec_legal = 1'b0;
        endcase
        if (!dec_legal) begin
            dec_sel = SEL_ADD;
            dec_sh  = '0;
            dec_a   = '0;
            dec_b   = '0;
        end
    end

    logic                  alu_valid_q, alu_valid_d;
    logic [SEL_SIZE-1:0]   alu_sel_q, alu_sel_d;
    logic [SHIFT_SIZE-1:0] alu_shift_amt_q, alu_shift_amt_d;
    logic [XLEN-1:0]       alu_data_a_q, alu_data_a_d;
    logic [XLEN-1:0]       alu_data_b_q, alu_data_b_d;
    logic [REG_ADDR-1:0]   rd_addr_q, rd_addr_d;
    logic                  rd_we_q, rd_we_d;
    logic                  illegal_q, illegal_d;
    logic [31:0]           issue_count_q, issue_count_d;
    logic                  accept;

    assign instr_ready = !flush && (!alu_valid_q || alu_ready);
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        alu_valid_d     = alu_valid_q;
        alu_sel_d       = alu_sel_q;
        alu_shift_amt_d = alu_shift_amt_q;
        alu_data_a_d    = alu_data_a_q;
        alu_data_b_d    = alu_data_b_q;
        rd_addr_d       = rd_addr_q;
        rd_we_d         = rd_we_q;
        illegal_d       = illegal_q;
        issue_count_d   = issue_count_q;
        if (alu_valid_q && alu_ready && !flush) begin
            issue_count_d = issue_count_q + 32'd1;
        end
        if (flush) begin
            alu_valid_d = 1'b0;
        end else if (accept) begin
            alu_valid_d     = 1'b1;
            alu_sel_d       = dec_sel;
            alu_shift_amt_d = dec_sh;
            alu_data_a_d    = dec_a;
            alu_data_b_d    = dec_b;
            rd_addr_d       = instr[11:7];
            rd_we_d         = dec_legal && (instr[11:7] != 5'd0);
            illegal_d       = !dec_legal;
        end else if (alu_ready) begin
            alu_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_valid_q     <= 1'b0;
            alu_sel_q       <= '0;
            alu_shift_amt_q <= '0;
            alu_data_a_q    <= '0;
            alu_data_b_q    <= '0;
            rd_addr_q       <= '0;
            rd_we_q         <= 1'b0;
            illegal_q       <= 1'b0;
            issue_count_q   <= '0;
        end else begin
            alu_valid_q     <= alu_valid_d;
            alu_sel_q       <= alu_sel_d;
            alu_shift_amt_q <= alu_shift_amt_d;
            alu_data_a_q    <= alu_data_a_d;
            alu_data_b_q    <= alu_data_b_d;
            rd_addr_q       <= rd_addr_d;
            rd_we_q         <= rd_we_d;
            illegal_q       <= illegal_d;
            issue_count_q   <= issue_count_d;
        end
    end

    assign alu_valid     = alu_valid_q;
    assign alu_sel       = alu_sel_q;
    assign alu_shift_amt = alu_shift_amt_q;
    assign alu_data_a    = alu_data_a_q;
    assign alu_data_b    = alu_data_b_q;
    assign rd_addr       = rd_addr_q;
    assign rd_we         = rd_we_q;
    assign illegal       = illegal_q;
    assign issue_count   = issue_count_q;

endmodule

// File: tb/tb_decode_execute_stage.sv
// Bench for decode_execute_stage: instruction-level reference model with a
// per-cycle compare process, plus directed vectors with literal expectations.
module tb_decode_execute_stage;

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] IMM = 7'b0010011;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] AUI = 7'b0010111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_sel;
    logic [4:0]  alu_shift_amt;
    logic [31:0] alu_data_a;
    logic [31:0] alu_data_b;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        illegal;
    logic [31:0] issue_count;

    always #5 clk = ~clk;

    decode_execute_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .pc(pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_sel(alu_sel), .alu_shift_amt(alu_shift_amt),
        .alu_data_a(alu_data_a), .alu_data_b(alu_data_b),
        .rd_addr(rd_addr), .rd_we(rd_we), .illegal(illegal),
        .issue_count(issue_count)
    );

    typedef struct packed {
        logic [3:0]  sel;
        logic [4:0]  sh;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } op_t;

    op_t         m_op;
    logic        m_valid;
    logic [31:0] m_cnt;
    bit          run = 1'b0;
    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7,
        input logic [4:0] s2, input logic [4:0] s1, input logic [2:0] f3,
        input logic [4:0] rd, input logic [6:0] opc);
        return {f7, s2, s1, f3, rd, opc};
    endfunction

    // ISA-level meaning of one instruction word
    function automatic op_t ref_decode(input logic [31:0] i,
        input logic [31:0] p, input logic [31:0] r1, input logic [31:0] r2);
        int   f3_sel [8] = '{0, 7, 2, 3, 6, 8, 5, 4};
        op_t  o;
        logic ok;
        int   f3, f7;
        f3 = int'(i[14:12]);
        f7 = int'(i[31:25]);
        o = '0;
        ok = 1'b0;
        o.rd = i[11:7];
        if (i[6:0] == OP) begin
            o.a = r1; o.b = r2; o.sh = r2[4:0];
            if (f7 == 0) begin ok = 1; o.sel = 4'(f3_sel[f3]); end
            else if (f7 == 32 && f3 == 0) begin ok = 1; o.sel = 4'd1; end
            else if (f7 == 32 && f3 == 5) begin ok = 1; o.sel = 4'd9; end
        end else if (i[6:0] == IMM) begin
            o.a = r1;
            o.b = 32'($signed(i[31:20]));
            o.sh = i[24:20];
            o.sel = 4'(f3_sel[f3]);
            ok = 1;
            if (f3 == 1 && f7 != 0) ok = 0;
            if (f3 == 5 && f7 == 32) o.sel = 4'd9;
            if (f3 == 5 && f7 != 0 && f7 != 32) ok = 0;
        end else if (i[6:0] == LUI) begin
            ok = 1; o.sel = 4'd10; o.a = {12'd0, i[31:12]};
        end else if (i[6:0] == AUI) begin
            ok = 1; o.sel = 4'd11; o.a = {12'd0, i[31:12]}; o.b = p;
        end
        if (!ok) begin
            o.sel = 0; o.a = 0; o.b = 0; o.sh = 0;
        end
        o.ill = !ok;
        o.we = ok && (o.rd != 0);
        return o;
    endfunction

    task automatic drive(input logic v, input logic [31:0] i,
        input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
        instr_valid = v; instr = i; pc = p; rs1_data = a; rs2_data = b;
    endtask

    task automatic model_reset();
        m_op = '0; m_valid = 1'b0; m_cnt = 32'd0;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge
    task automatic cycle();
        op_t  d;
        logic take;
        logic fire;
        take = instr_valid && !flush && (!m_valid || alu_ready);
        fire = m_valid && alu_ready && !flush;
        d = ref_decode(instr, pc, rs1_data, rs2_data);
        @(posedge clk);
        if (fire) m_cnt = m_cnt + 32'd1;
        if (flush) m_valid = 1'b0;
        else if (take) begin m_op = d; m_valid = 1'b1; end
        else if (alu_ready) m_valid = 1'b0;
        #1;
    endtask

    always @(negedge clk) begin
        if (run && rst_n) begin
            chk("instr_ready", 32'(instr_ready),
                32'(!flush && (!m_valid || alu_ready)));
            chk("rs1_addr", 32'(rs1_addr), 32'(instr[19:15]));
            chk("rs2_addr", 32'(rs2_addr), 32'(instr[24:20]));
            chk("alu_valid", 32'(alu_valid), 32'(m_valid));
            chk("alu_sel", 32'(alu_sel), 32'(m_op.sel));
            chk("shift_amt", 32'(alu_shift_amt), 32'(m_op.sh));
            chk("data_a", alu_data_a, m_op.a);
            chk("data_b", alu_data_b, m_op.b);
            chk("rd_addr", 32'(rd_addr), 32'(m_op.rd));
            chk("rd_we", 32'(rd_we), 32'(m_op.we));
            chk("illegal", 32'(illegal), 32'(m_op.ill));
            chk("issue_count", issue_count, m_cnt);
        end
    end

    logic [31:0] vec_i [16];
    logic [31:0] saved;

    task automatic check_test1();
        drive(1, 32'hFFF10093, 32'h100, 32'd5, 32'd0);
        alu_ready = 1;
        #0 chk("t1 rs1_addr", 32'(rs1_addr), 32'd2);
        cycle();
        chk("t1 valid", 32'(alu_valid), 32'd1);
        chk("t1 sel", 32'(alu_sel), 32'd0);
        chk("t1 a", alu_data_a, 32'd5);
        chk("t1 b", alu_data_b, 32'hFFFFFFFF);
        chk("t1 rd", 32'(rd_addr), 32'd1);
        chk("t1 we", 32'(rd_we), 32'd1);
    endtask

    initial begin
        rst_n = 0; flush = 0; alu_ready = 0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        #12;
        chk("rst valid", 32'(alu_valid), 32'd0);
        chk("rst count", issue_count, 32'd0);
        chk("rst data_a", alu_data_a, 32'd0);
        @(posedge clk); #1 rst_n = 1;
        run = 1'b1;

        check_test1();

        drive(1, 32'h40208033, 32'h104, 32'd9, 32'd3);
        cycle();
        chk("t2 sel", 32'(alu_sel), 32'd1);
        chk("t2 rd", 32'(rd_addr), 32'd0);
        chk("t2 we", 32'(rd_we), 32'd0);
        chk("t2 illegal", 32'(illegal), 32'd0);
        chk("t2 count", issue_count, 32'd1);

        drive(1, 32'h123452B7, 32'h108, 32'd0, 32'd0);
        cycle();
        chk("t3 sel", 32'(alu_sel), 32'd10);
        chk("t3 a", alu_data_a, 32'h00012345);
        alu_ready = 0;
        drive(1, enc(0, 2, 1, 0, 3, OP), 32'h10C, 32'd7, 32'd8);
        for (int k = 0; k < 3; k++) begin
            #0 chk("t3 stall ready", 32'(instr_ready), 32'd0);
            cycle();
            chk("t3 held sel", 32'(alu_sel), 32'd10);
            chk("t3 held count", issue_count, 32'd2);
        end
        alu_ready = 1;
        cycle();
        chk("t3 count", issue_count, 32'd3);
        chk("t3 next a", alu_data_a, 32'd7);

        drive(1, 32'h40725193, 32'h110, 32'h80000000, 32'd0);
        cycle();
        chk("t4 sel", 32'(alu_sel), 32'd9);
        chk("t4 shamt", 32'(alu_shift_amt), 32'd7);
        drive(1, 32'h40721193, 32'h114, 32'h1234, 32'd0);
        cycle();
        chk("t4 illegal", 32'(illegal), 32'd1);
        chk("t4 we", 32'(rd_we), 32'd0);
        chk("t4 a", alu_data_a, 32'd0);

        vec_i[0]  = enc(0, 3, 4, 1, 5, OP);
        vec_i[1]  = enc(0, 3, 4, 2, 5, OP);
        vec_i[2]  = enc(0, 3, 4, 3, 5, OP);
        vec_i[3]  = enc(0, 3, 4, 4, 5, OP);
        vec_i[4]  = enc(0, 3, 4, 5, 5, OP);
        vec_i[5]  = enc(0, 3, 4, 6, 5, OP);
        vec_i[6]  = enc(0, 3, 4, 7, 5, OP);
        vec_i[7]  = enc(7'h20, 3, 4, 5, 5, OP);
        vec_i[8]  = enc(7'h01, 3, 4, 0, 5, OP);
        vec_i[9]  = enc(7'h20, 3, 4, 2, 5, OP);
        vec_i[10] = {12'h800, 5'd4, 3'b111, 5'd6, IMM};
        vec_i[11] = {12'h7FF, 5'd4, 3'b011, 5'd6, IMM};
        vec_i[12] = enc(0, 31, 4, 1, 6, IMM);
        vec_i[13] = enc(7'h10, 3, 4, 5, 6, IMM);
        vec_i[14] = {20'hABCDE, 5'd7, AUI};
        vec_i[15] = 32'h0000007F;
        for (int k = 0; k < 16; k++) begin
            alu_ready = (k % 3) != 2;
            drive((k % 4) != 3, vec_i[k], 32'h8000_0040 + 32'(4 * k),
                  32'hF000_0000 + 32'(k), 32'h25 + 32'(k));
            cycle();
        end
        alu_ready = 1;
        drive(1, vec_i[14], 32'h8000_0040, 32'd0, 32'd0);
        cycle();
        chk("auipc a", alu_data_a, 32'h000ABCDE);
        chk("auipc b", alu_data_b, 32'h80000040);
        drive(1, vec_i[4], 32'h200, 32'hFFFF0000, 32'h25);
        cycle();
        chk("srl shamt", 32'(alu_shift_amt), 32'd5);
        drive(1, vec_i[15], 32'h204, 32'd1, 32'd1);
        cycle();
        chk("bad opcode illegal", 32'(illegal), 32'd1);

        alu_ready = 0;
        drive(1, vec_i[0], 32'h208, 32'd1, 32'd2);
        cycle();
        flush = 1;
        #0 chk("t5 ready", 32'(instr_ready), 32'd0);
        saved = m_cnt;
        cycle();
        chk("t5 valid", 32'(alu_valid), 32'd0);
        chk("t5 count", issue_count, saved);
        flush = 0; alu_ready = 1;
        cycle();
        flush = 1;
        saved = m_cnt;
        cycle();
        chk("t5b valid", 32'(alu_valid), 32'd0);
        chk("t5b count", issue_count, saved);
        flush = 0;

        alu_ready = 0;
        drive(1, 32'hFFF10093, 32'h300, 32'd9, 32'd0);
        cycle();
        #2 rst_n = 0;
        #1;
        chk("t6 valid", 32'(alu_valid), 32'd0);
        chk("t6 count", issue_count, 32'd0);
        chk("t6 data_b", alu_data_b, 32'd0);
        chk("t6 sel", 32'(alu_sel), 32'd0);
        model_reset();
        drive(0, 0, 0, 0, 0);
        @(posedge clk); #1 rst_n = 1;
        cycle();
        check_test1();
        chk("t6 count after", issue_count, 32'd0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
